// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct codes, ALUOp codes and control bundle shared by control_pipe
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_SPECIAL3 = 6'b011111;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MOVZ  = 6'b001010;
  localparam logic [5:0] F_MOVN  = 6'b001011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [5:0] F2_MADD = 6'b000000;
  localparam logic [5:0] F2_MUL  = 6'b000010;
  localparam logic [5:0] F2_MSUB = 6'b000100;

  localparam logic [4:0] SH_SEB = 5'b10000;
  localparam logic [4:0] SH_SEH = 5'b11000;

  localparam logic [5:0] ALU_ADD   = 6'b000001;
  localparam logic [5:0] ALU_ADDU  = 6'b000010;
  localparam logic [5:0] ALU_SUB   = 6'b000011;
  localparam logic [5:0] ALU_MUL   = 6'b000100;
  localparam logic [5:0] ALU_MULT  = 6'b000101;
  localparam logic [5:0] ALU_MULTU = 6'b000110;
  localparam logic [5:0] ALU_MADD  = 6'b000111;
  localparam logic [5:0] ALU_MSUB  = 6'b001000;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011001;
  localparam logic [5:0] ALU_NOR   = 6'b011010;
  localparam logic [5:0] ALU_XOR   = 6'b011011;
  localparam logic [5:0] ALU_SEH   = 6'b011100;
  localparam logic [5:0] ALU_SLL   = 6'b011101;
  localparam logic [5:0] ALU_SRL   = 6'b011110;
  localparam logic [5:0] ALU_SLT   = 6'b011111;
  localparam logic [5:0] ALU_MOVN  = 6'b100000;
  localparam logic [5:0] ALU_MOVZ  = 6'b100001;
  localparam logic [5:0] ALU_ROTR  = 6'b100010;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_SEB   = 6'b100100;
  localparam logic [5:0] ALU_SLTU  = 6'b100101;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       hilo_ctl;
    logic       zero_extend;
    logic [5:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Instructions that occupy the shared HI/LO multiplier.
  function automatic logic is_mul_class(input logic [5:0] op, input logic [5:0] funct);
    return ((op == OP_RTYPE) && ((funct == F_MULT) || (funct == F_MULTU))) ||
           ((op == OP_SPECIAL2) &&
            ((funct == F2_MUL) || (funct == F2_MADD) || (funct == F2_MSUB)));
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational MIPS instruction to control bundle decode
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl_bits,
  output logic              illegal,
  output logic              is_mul
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;
  ctrl_t      c;
  logic       bad;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign shamt         = instr[10:6];
  assign unused_fields = ^{instr[25:22], instr[20:11]};

  always_comb begin
    c   = '0;
    bad = 1'b0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          F_ADD:          c.alu_op = ALU_ADD;
          F_ADDU:         c.alu_op = ALU_ADDU;
          F_SUB:          c.alu_op = ALU_SUB;
          F_AND:          c.alu_op = ALU_AND;
          F_OR:           c.alu_op = ALU_OR;
          F_NOR:          c.alu_op = ALU_NOR;
          F_XOR:          c.alu_op = ALU_XOR;
          F_SLL, F_SLLV:  c.alu_op = ALU_SLL;
          // rotate variants reuse the logical-shift funct codes, selected by bit 21 / bit 6
          F_SRL:          c.alu_op = instr[21] ? ALU_ROTR : ALU_SRL;
          F_SRLV:         c.alu_op = instr[6] ? ALU_ROTR : ALU_SRL;
          F_SRA, F_SRAV:  c.alu_op = ALU_SRA;
          F_SLT:          c.alu_op = ALU_SLT;
          F_SLTU:         c.alu_op = ALU_SLTU;
          F_MOVN:         c.alu_op = ALU_MOVN;
          F_MOVZ:         c.alu_op = ALU_MOVZ;
          F_MULT, F_MULTU: begin
            c.alu_op    = (funct == F_MULT) ? ALU_MULT : ALU_MULTU;
            c.reg_dst   = 1'b0;
            c.reg_write = 1'b0;
            c.hilo_ctl  = 1'b1;
          end
          default:        bad = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        c.alu_src     = 1'b1;
        c.reg_write   = 1'b1;
        c.zero_extend = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        case (op)
          OP_ADDI:  c.alu_op = ALU_ADD;
          OP_ADDIU: c.alu_op = ALU_ADDU;
          OP_SLTI:  c.alu_op = ALU_SLT;
          OP_SLTIU: c.alu_op = ALU_SLTU;
          OP_ANDI:  c.alu_op = ALU_AND;
          OP_ORI:   c.alu_op = ALU_OR;
          default:  c.alu_op = ALU_XOR;
        endcase
      end
      OP_SPECIAL2: begin
        c.hilo_ctl = 1'b1;
        c.reg_dst  = 1'b1;
        case (funct)
          F2_MUL: begin
            c.alu_op    = ALU_MUL;
            c.reg_write = 1'b1;
          end
          F2_MADD: c.alu_op = ALU_MADD;
          F2_MSUB: c.alu_op = ALU_MSUB;
          default: bad = 1'b1;
        endcase
      end
      OP_SPECIAL3: begin
        c.reg_dst   = 1'b1;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        case (shamt)
          SH_SEB:  c.alu_op = ALU_SEB;
          SH_SEH:  c.alu_op = ALU_SEH;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // an illegal encoding must never enable a write; the trap rides along on Illegal
    if (bad) begin
      c = '0;
    end
  end

  assign ctrl_bits = c;
  assign illegal   = bad;
  assign is_mul    = is_mul_class(op, funct);

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - registered ID/EX control decode with handshake, stall, flush and HI/LO interlock
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 6,
  parameter int MUL_LATENCY = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [31:0]        InstrIn,
  input  logic               InValid,
  output logic               InReady,
  input  logic               Stall,
  input  logic               Flush,
  output logic               OutValid,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               Branch,
  output logic               HiLoCtl,
  output logic               ZeroExtend,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Illegal,
  output logic               HiLoBusy
);

  // The issuing cycle is the first busy cycle, so the counter holds the remaining
  // MUL_LATENCY-1 cycles; the next multiply issues exactly MUL_LATENCY cycles later.
  localparam int CNT_W    = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam int LOAD_INT = (MUL_LATENCY > 0) ? MUL_LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(LOAD_INT);

  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec_ctrl;
  logic              dec_illegal;
  logic              dec_is_mul;
  logic              accept;
  logic [CNT_W-1:0]  mul_cnt;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic              illegal_q;

  ctrl_decode u_decode (
    .instr     (InstrIn),
    .ctrl_bits (dec_bits),
    .illegal   (dec_illegal),
    .is_mul    (dec_is_mul)
  );

  assign dec_ctrl = ctrl_t'(dec_bits);
  assign HiLoBusy = (mul_cnt != '0);
  assign InReady  = !Stall && !(HiLoBusy && dec_is_mul);
  assign accept   = InValid && InReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mul_cnt   <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // a flushed multiply has still issued to HI/LO, so the interlock ignores Flush
      if (accept && dec_is_mul) begin
        mul_cnt <= MUL_LOAD;
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end

      if (Flush) begin
        ctrl_q    <= '0;
        valid_q   <= 1'b0;
        illegal_q <= 1'b0;
      end else if (Stall) begin
        ctrl_q    <= ctrl_q;
        valid_q   <= valid_q;
        illegal_q <= illegal_q;
      end else if (accept) begin
        ctrl_q    <= dec_ctrl;
        valid_q   <= 1'b1;
        illegal_q <= dec_illegal;
      end else begin
        ctrl_q    <= '0;
        valid_q   <= 1'b0;
        illegal_q <= 1'b0;
      end
    end
  end

  assign OutValid   = valid_q;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemRead    = ctrl_q.mem_read;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign RegDst     = ctrl_q.reg_dst;
  assign ALUSrc     = ctrl_q.alu_src;
  assign Branch     = ctrl_q.branch;
  assign HiLoCtl    = ctrl_q.hilo_ctl;
  assign ZeroExtend = ctrl_q.zero_extend;
  assign ALUOp      = ALUOP_W'(ctrl_q.alu_op);
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - scoreboard bench for control_pipe against a table-driven decode model
module tb_control_pipe;

  localparam int L = 4;

  // control vector order: RegWrite MemWrite MemRead MemtoReg RegDst ALUSrc Branch HiLoCtl ZeroExtend
  localparam logic [8:0] M_FULL  = 9'b111111111;
  localparam logic [8:0] M_ILL   = 9'b111100110;
  localparam logic [8:0] M_MULT  = 9'b011100100;
  localparam logic [8:0] M_SP2   = 9'b011100110;
  localparam logic [8:0] M_EN    = 9'b111100110;
  localparam logic [8:0] C_R     = 9'b100010000;
  localparam logic [8:0] C_I     = 9'b100001000;
  localparam logic [8:0] C_IZ    = 9'b100001001;
  localparam logic [8:0] C_SP2   = 9'b000000010;
  localparam logic [8:0] C_SP3   = 9'b100011000;

  localparam logic [31:0] I_MULT = 32'h00220018;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] InstrIn = 32'h0;
  logic        InValid = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        InReady, OutValid, RegWrite, MemWrite, MemRead, MemtoReg, RegDst, ALUSrc;
  logic        Branch, HiLoCtl, ZeroExtend, Illegal, HiLoBusy;
  logic [5:0]  ALUOp;

  always #5 Clk = ~Clk;

  control_pipe #(.ALUOP_W(6), .MUL_LATENCY(L)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InstrIn(InstrIn), .InValid(InValid), .InReady(InReady),
    .Stall(Stall), .Flush(Flush), .OutValid(OutValid), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .Branch(Branch), .HiLoCtl(HiLoCtl), .ZeroExtend(ZeroExtend),
    .ALUOp(ALUOp), .Illegal(Illegal), .HiLoBusy(HiLoBusy)
  );

  typedef struct {
    bit         valid;
    bit         hold;
    bit         flush;
    logic [8:0] ctl;
    logic [8:0] mask;
    logic [5:0] aluop;
    bit         illegal;
  } rec_t;

  rec_t q[$];
  rec_t last;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_mul = -1000;

  logic [5:0] r_fns [19] = '{6'b100000, 6'b100001, 6'b100010, 6'b011000, 6'b011001,
                             6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b000000,
                             6'b000010, 6'b000100, 6'b000110, 6'b000011, 6'b000111,
                             6'b101010, 6'b101011, 6'b001011, 6'b001010};
  logic [5:0] i_ops [7]  = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110,
                             6'b001010, 6'b001011};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t empty_rec();
    rec_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic bit model_is_mul(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'b000000) return (fn == 6'b011000) || (fn == 6'b011001);
    if (op == 6'b011100) return (fn == 6'b000010) || (fn == 6'b000000) || (fn == 6'b000100);
    return 1'b0;
  endfunction

  // Expected registered outputs for an accepted instruction, straight from the decode table.
  function automatic rec_t model(input logic [31:0] ins);
    rec_t r;
    logic [5:0] op, fn;
    logic [4:0] sh;
    bit bad;
    op = ins[31:26];
    fn = ins[5:0];
    sh = ins[10:6];
    bad = 1'b0;
    r = empty_rec();
    r.valid = 1'b1;
    r.mask = M_FULL;
    case (op)
      6'b000000: begin
        r.ctl = C_R;
        case (fn)
          6'b100000: r.aluop = 6'b000001;
          6'b100001: r.aluop = 6'b000010;
          6'b100010: r.aluop = 6'b000011;
          6'b100100: r.aluop = 6'b011000;
          6'b100101: r.aluop = 6'b011001;
          6'b100111: r.aluop = 6'b011010;
          6'b100110: r.aluop = 6'b011011;
          6'b000000: r.aluop = 6'b011101;
          6'b000010: r.aluop = ins[21] ? 6'b100010 : 6'b011110;
          6'b000100: r.aluop = 6'b011101;
          6'b000110: r.aluop = ins[6] ? 6'b100010 : 6'b011110;
          6'b000011: r.aluop = 6'b100011;
          6'b000111: r.aluop = 6'b100011;
          6'b101010: r.aluop = 6'b011111;
          6'b101011: r.aluop = 6'b100101;
          6'b001011: r.aluop = 6'b100000;
          6'b001010: r.aluop = 6'b100001;
          6'b011000: begin r.aluop = 6'b000101; r.mask = M_MULT; end
          6'b011001: begin r.aluop = 6'b000110; r.mask = M_MULT; end
          default:   bad = 1'b1;
        endcase
      end
      6'b001000: begin r.ctl = C_I;  r.aluop = 6'b000001; end
      6'b001001: begin r.ctl = C_I;  r.aluop = 6'b000010; end
      6'b001100: begin r.ctl = C_IZ; r.aluop = 6'b011000; end
      6'b001101: begin r.ctl = C_IZ; r.aluop = 6'b011001; end
      6'b001110: begin r.ctl = C_IZ; r.aluop = 6'b011011; end
      6'b001010: begin r.ctl = C_I;  r.aluop = 6'b011111; end
      6'b001011: begin r.ctl = C_I;  r.aluop = 6'b100101; end
      6'b011100: begin
        r.ctl = C_SP2;
        r.mask = M_SP2;
        if (fn == 6'b000010)      r.aluop = 6'b000100;
        else if (fn == 6'b000000) r.aluop = 6'b000111;
        else if (fn == 6'b000100) r.aluop = 6'b001000;
        else bad = 1'b1;
      end
      6'b011111: begin
        r.ctl = C_SP3;
        if (sh == 5'b10000)      r.aluop = 6'b100100;
        else if (sh == 5'b11000) r.aluop = 6'b011100;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      r.ctl = '0;
      r.aluop = '0;
      r.mask = M_ILL;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin w[31:26] = 6'b000000; w[5:0] = r_fns[$urandom_range(0, 18)]; end
      3:       begin w[31:26] = 6'b000000; w[5:0] = $urandom_range(0, 1) ? 6'b011000 : 6'b011001; end
      4, 5:    w[31:26] = i_ops[$urandom_range(0, 6)];
      6: begin
        w[31:26] = 6'b011100;
        case ($urandom_range(0, 3))
          0: w[5:0] = 6'b000010;
          1: w[5:0] = 6'b000000;
          2: w[5:0] = 6'b000100;
          default: ;
        endcase
      end
      7: begin
        w[31:26] = 6'b011111;
        w[5:0] = 6'b100000;
        case ($urandom_range(0, 2))
          0: w[10:6] = 5'b10000;
          1: w[10:6] = 5'b11000;
          default: ;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  // One clock of stimulus: drive at negedge, check handshake, push expected result at posedge.
  task automatic step(input logic [31:0] ins, input logic v, input logic s, input logic f);
    rec_t r;
    bit ismul, busy, ready;
    @(negedge Clk);
    InstrIn = ins;
    InValid = v;
    Stall = s;
    Flush = f;
    #1;
    ismul = model_is_mul(ins);
    busy = (cyc + 1 - last_mul) < L;
    ready = !s && !(ismul && busy);
    check("in_ready", 32'(InReady), 32'(ready));
    check("hilo_busy", 32'(HiLoBusy), 32'(busy));
    @(posedge Clk);
    cyc++;
    if (v && ready && ismul) last_mul = cyc;
    r = empty_rec();
    if (f) r.flush = 1'b1;
    else if (s) r.hold = 1'b1;
    else if (v && ready) r = model(ins);
    q.push_back(r);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 32'(OutValid), 32'd0);
    check({tag, "_ctl"}, 32'({RegWrite, MemWrite, MemRead, MemtoReg, RegDst, ALUSrc,
                              Branch, HiLoCtl, ZeroExtend}), 32'd0);
    check({tag, "_aluop"}, 32'(ALUOp), 32'd0);
    check({tag, "_illegal"}, 32'(Illegal), 32'd0);
    check({tag, "_hilo_busy"}, 32'(HiLoBusy), 32'd0);
    check({tag, "_in_ready"}, 32'(InReady), 32'd1);
  endtask

  initial begin : monitor
    rec_t r;
    logic [8:0] act;
    forever begin
      @(negedge Clk);
      #2;
      if (q.size() > 0) begin
        r = q.pop_front();
        if (r.hold) r = last;
        else last = r;
        act = {RegWrite, MemWrite, MemRead, MemtoReg, RegDst, ALUSrc, Branch, HiLoCtl, ZeroExtend};
        check("out_valid", 32'(OutValid), 32'(r.valid));
        if (r.valid) begin
          check("aluop", 32'(ALUOp), 32'(r.aluop));
          check("illegal", 32'(Illegal), 32'(r.illegal));
          check("ctl", 32'(act & r.mask), 32'(r.ctl & r.mask));
        end else begin
          check("bubble_enables", 32'(act & M_EN), 32'd0);
          if (r.flush) check("flush_illegal", 32'(Illegal), 32'd0);
        end
      end
    end
  end

  initial begin
    last = empty_rec();
    #1;
    reset_checks("reset");
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    step(32'h00221820, 1, 0, 0);  // add
    step(32'h00011042, 1, 0, 0);  // srl
    step(32'h00211042, 1, 0, 0);  // rotr
    step(32'h30220005, 1, 0, 0);  // andi
    step(32'h24220005, 1, 0, 0);  // addiu
    step(32'h7C021C20, 1, 0, 0);  // seb
    step(32'h70221802, 1, 0, 0);  // mul
    step(32'h00000000, 0, 0, 0);
    repeat (4) step(32'h00000000, 0, 0, 0);

    step(I_MULT, 1, 0, 0);
    repeat (5) step(I_MULT, 1, 0, 0);
    step(I_MULT, 1, 0, 0);
    step(32'h00221821, 1, 0, 0);  // addu passes during busy
    step(I_MULT, 1, 0, 0);
    repeat (4) step(I_MULT, 1, 0, 0);

    step(32'h00221820, 1, 0, 0);
    repeat (3) step(32'h00221822, 1, 1, 0);  // stall holds add
    step(32'h00221822, 1, 1, 1);             // flush beats stall
    step(32'h00221822, 1, 0, 0);
    step(32'hFC000000, 1, 0, 0);             // illegal opcode
    step(32'h00000000, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      step(rand_instr(), $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    repeat (L) step(32'h00000000, 0, 0, 0);
    step(I_MULT, 1, 0, 0);
    @(negedge Clk);
    #3;
    InValid = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    InstrIn = I_MULT;
    Rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    q.delete();
    last = empty_rec();
    last_mul = -1000;
    @(negedge Clk);
    Rst_n = 1'b1;
    step(I_MULT, 1, 0, 0);
    step(32'h00221820, 1, 0, 0);
    step(32'h00000000, 0, 0, 0);

    @(negedge Clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
